mix_job_sched: RTL and testbench
================================

Name: mix_job_sched

Overview:
- Scheduler that shares one iterative 32-bit mixing core among NREQ requesters.
- Each accepted job runs the core ROUNDS times back-to-back. Each pass's result is fed back as the next pass's seed.
- The final value is returned on a response channel tagged with the requester index.
- Sits between the stimulus/testbench agents and the mixing datapath. The block owns arbitration, round sequencing and a per-pass watchdog.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, seed/result width.
- ROUNDS, 16, core passes per job (1..255).
- TIMEOUT, 64, max cycles in WAIT per pass before abort (2..1023).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- req_valid  in  NREQ  per-requester job request.
- req_seed  in  NREQ*WIDTH  per-requester seed, lane i at bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant/accept.
- core_start  out  1  one-cycle pulse launching one core pass.
- core_seed  out  WIDTH  operand for the current pass.
- core_done  in  1  core pass complete; qualifies core_result.
- core_result  in  WIDTH  core output.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  3  index of the requester served.
- rsp_data  out  WIDTH  final mixed value.
- rsp_err  out  1  job aborted by watchdog.
- busy  out  1  state != IDLE.
- jobs_done  out  16  count of completed responses (ok or err); wraps at 0xFFFF->0.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; rr_ptr=0; round_cnt=0; timer=0; work=0.
  - Outputs: core_start=0, core_seed=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, jobs_done=0.
  - req_ready=0 while rst_n=0.
  - Reset mid-job abandons the job with no response. A later core_done is ignored because state is IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 combinationally; all other bits are 0.
  - On that edge: work<=req_seed[g], rsp_id<=g, rr_ptr<=(g+1) mod NREQ, round_cnt<=0, go to ISSUE.
  - No valid requester: stay in IDLE.
  - req_ready is 0 in every other state.
- ISSUE:
  - core_start=1 and core_seed=work for exactly this cycle; timer<=0; go to WAIT.
  - core_seed holds its value outside ISSUE.
- WAIT, each cycle timer<=timer+1:
  - core_done=1:
    - work<=core_result.
    - If round_cnt==ROUNDS-1: rsp_data<=core_result, rsp_err<=0, go to RESP.
    - Otherwise: round_cnt<=round_cnt+1, go to ISSUE.
  - core_done=0 and timer==TIMEOUT-1: rsp_data<=work (last good value), rsp_err<=1, go to RESP.
  - core_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_data/rsp_err held stable until rsp_ready=1.
  - On that edge: jobs_done++, go to IDLE.
  - No new grant occurs in the RESP->IDLE transition cycle. The earliest next grant is the following cycle.
- core_done outside WAIT is ignored.
- Latency with core done d cycles after start (d>=1): grant edge to rsp_valid = ROUNDS*(d+1) cycles.
- Round-robin fairness: with all requesters valid, grants cycle 0,1,2,3,0,...
  - rr_ptr advances only on a grant, never on a timeout or reset.
- Arithmetic: counters are unsigned; no width extension of data. The scheduler never modifies data.

Test Plan:
- Stub core returns seed+1 with d=3. req_valid=0001, seed=0x00000001, ROUNDS=16 -> rsp_valid 64 cycles after grant, rsp_data=0x00000011, rsp_id=0, rsp_err=0, jobs_done=1.
- All four req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. Each req_ready is a single-cycle pulse, and never two bits at once.
- Stub never asserts core_done, seed=0xDEADBEEF -> rsp_valid after TIMEOUT+1 cycles of the first pass, rsp_err=1, rsp_data=0xDEADBEEF. The next job then completes normally.
- core_done coincides with timer==TIMEOUT-1 -> pass accepted, no error, round_cnt advances.
- rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable all 10 cycles, no grants issued, jobs_done increments once on acceptance.
- rst_n low for one cycle during WAIT of round 5, with core_done arriving after reset -> no response, busy=0, jobs_done=0, rr_ptr=0. The next request from requester 2 is granted first.

Source files
------------

// File: rtl/mix_job_sched.sv
// Round-robin job scheduler in front of one shared iterative mixing core.
// Each job takes ROUNDS back-to-back core passes, and every pass has its own watchdog.
module mix_job_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int ROUNDS  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_seed,
    output logic [NREQ-1:0]       req_ready,
    output logic                  core_start,
    output logic [WIDTH-1:0]      core_seed,
    input  logic                  core_done,
    input  logic [WIDTH-1:0]      core_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2:0]            rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [15:0]           jobs_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         rr_ptr_reg, rr_ptr_next;
    logic [7:0]         round_cnt_reg, round_cnt_next;
    logic [9:0]         timer_reg, timer_next;
    logic [WIDTH-1:0]   work_reg, work_next;
    logic               core_start_reg, core_start_next;
    logic [WIDTH-1:0]   core_seed_reg, core_seed_next;
    logic [2:0]         rsp_id_reg, rsp_id_next;
    logic [WIDTH-1:0]   rsp_data_reg, rsp_data_next;
    logic               rsp_err_reg, rsp_err_next;
    logic [15:0]        jobs_done_reg, jobs_done_next;

    // Lanes are padded to 8 so a 3-bit index always addresses a real element.
    logic [7:0]         req_valid_pad;
    logic [WIDTH-1:0]   seed_lane [8];
    logic               grant_found;
    logic [2:0]         grant_idx;
    logic [7:0]         grant_onehot;

    assign req_valid_pad = 8'(req_valid);

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        if (gi < NREQ) begin : g_used
            assign seed_lane[gi] = req_seed[gi*WIDTH +: WIDTH];
        end else begin : g_unused
            assign seed_lane[gi] = '0;
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin : arb
        logic [3:0] sum;
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        sum         = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_reg} + 4'(k);
            if (sum >= 4'(NREQ)) begin
                sum = sum - 4'(NREQ);
            end
            if (!grant_found && req_valid_pad[sum[2:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[2:0];
            end
        end
    end

    always_comb begin
        grant_onehot = 8'd0;
        if (rst_n && state_reg == IDLE && grant_found) begin
            grant_onehot = 8'd1 << grant_idx;
        end
    end

    assign req_ready = grant_onehot[NREQ-1:0];

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        round_cnt_next = round_cnt_reg;
        timer_next     = timer_reg;
        work_next      = work_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_err_next   = rsp_err_reg;
        jobs_done_next = jobs_done_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    work_next      = seed_lane[grant_idx];
                    rsp_id_next    = grant_idx;
                    rr_ptr_next    = (grant_idx == 3'(NREQ-1)) ? 3'd0 : grant_idx + 3'd1;
                    round_cnt_next = 8'd0;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                timer_next = 10'd0;
                state_next = WAIT;
            end
            WAIT: begin
                timer_next = timer_reg + 10'd1;
                // A done arriving on the last watchdog cycle still counts as success.
                if (core_done) begin
                    work_next = core_result;
                    if (round_cnt_reg == 8'(ROUNDS-1)) begin
                        rsp_data_next = core_result;
                        rsp_err_next  = 1'b0;
                        state_next    = RESP;
                    end else begin
                        round_cnt_next = round_cnt_reg + 8'd1;
                        state_next     = ISSUE;
                    end
                end else if (timer_reg == 10'(TIMEOUT-1)) begin
                    rsp_data_next = work_reg;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    jobs_done_next = jobs_done_reg + 16'd1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // The core operand is latched on entry to ISSUE and then held between passes.
        core_start_next = (state_next == ISSUE);
        core_seed_next  = (state_next == ISSUE) ? work_next : core_seed_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= 3'd0;
            round_cnt_reg  <= 8'd0;
            timer_reg      <= 10'd0;
            work_reg       <= '0;
            core_start_reg <= 1'b0;
            core_seed_reg  <= '0;
            rsp_id_reg     <= 3'd0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
            jobs_done_reg  <= 16'd0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            round_cnt_reg  <= round_cnt_next;
            timer_reg      <= timer_next;
            work_reg       <= work_next;
            core_start_reg <= core_start_next;
            core_seed_reg  <= core_seed_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_err_reg    <= rsp_err_next;
            jobs_done_reg  <= jobs_done_next;
        end
    end

    assign core_start = core_start_reg;
    assign core_seed  = core_seed_reg;
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_id     = rsp_id_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_err    = rsp_err_reg;
    assign busy       = (state_reg != IDLE);
    assign jobs_done  = jobs_done_reg;

endmodule

// File: tb/tb_mix_job_sched.sv
// Directed bench for mix_job_sched: a stub core returns seed+1 after a programmable delay.
// Expected responses are queued by the stimulus and checked by a separate monitor.
module tb_mix_job_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_seed;
    logic [NREQ-1:0]   req_ready;
    logic              core_start;
    logic [W-1:0]      core_seed;
    logic              core_done;
    logic [W-1:0]      core_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [15:0]       jobs_done;

    mix_job_sched #(.NREQ(NREQ), .WIDTH(W), .ROUNDS(16), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_seed(req_seed), .req_ready(req_ready),
        .core_start(core_start), .core_seed(core_seed),
        .core_done(core_done), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub core: done is raised stub_delay cycles after the start pulse.
    int         stub_delay = 3;
    bit         stub_hang  = 1'b0;
    logic       pending    = 1'b0;
    int         scnt       = 0;
    logic [W-1:0] sval     = '0;

    assign core_done   = pending && !stub_hang && (scnt == stub_delay);
    assign core_result = sval;

    always @(posedge clk) begin
        if (core_start) begin
            pending <= 1'b1;
            scnt    <= 1;
            sval    <= core_seed + 32'd1;
        end else if (core_done) begin
            pending <= 1'b0;
        end else if (pending) begin
            scnt <= scnt + 1;
        end
    end

    typedef struct {
        logic [2:0]   id;
        logic [W-1:0] data;
        logic         err;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_jobs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: grant legality and response scoreboard.
    logic [NREQ-1:0] prev_ready = '0;
    logic            prev_valid = 1'b0;
    int              grant_cyc = 0;
    int              rsp_start = 0;
    int              grants = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
                check("grant_pulse", 64'(prev_ready), 64'd0);
                grant_cyc = cyc;
                grants++;
            end
            if (rsp_valid && !prev_valid) rsp_start = cyc;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_id), 64'hFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (e.lat > 0) check("latency", 64'(rsp_start - (grant_cyc + 1)), 64'(e.lat));
                    $display("rsp id=%0d data=%08h err=%0d jobs_done=%0d", rsp_id, rsp_data, rsp_err, jobs_done);
                    check("jobs_done_pre", 64'(jobs_done), 64'(exp_jobs));
                    exp_jobs++;
                end
            end
        end
        prev_ready = rst_n ? req_ready : '0;
        prev_valid = rst_n ? rsp_valid : 1'b0;
    end

    task automatic push(input int id, input logic [W-1:0] data, input logic err, input int lat);
        exp_t e;
        e.id = 3'(id); e.data = data; e.err = err; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic set_seed(input int id, input logic [W-1:0] s);
        req_seed[id*W +: W] = s;
    endtask

    // Returns one negedge after the grant edge; caller may then drop the request.
    task automatic wait_grant(input int id);
        bit ok = 1'b0;
        #1;
        for (int i = 0; i < 3000; i++) begin
            if (req_ready[id]) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) check("grant_timeout", 64'(id), 64'hFF);
        @(negedge clk);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        req_seed  = '0;
        rsp_ready = 1'b1;
        set_seed(0, 32'h0000_0001);

        // Reset state, with a request pending that must not be accepted.
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_core_seed", 64'(core_seed), 64'd0);
        check("rst_rsp_fields", {29'd0, rsp_id, rsp_data}, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_jobs_done", 64'(jobs_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic job: 16 passes of +1 from 1, d=3.
        push(0, 32'h0000_0011, 1'b0, 64);
        wait_grant(0);
        req_valid[0] = 1'b0;
        drain();
        check("t1_jobs_done", 64'(jobs_done), 64'd1);

        // Fresh reset, all four requesting: expect 0,1,2,3,0.
        rst_n = 1'b0; exp_q.delete(); exp_jobs = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_seed(i, 32'h100 * (i + 1));
        push(0, 32'h110, 1'b0, 64);
        push(1, 32'h210, 1'b0, 64);
        push(2, 32'h310, 1'b0, 64);
        push(3, 32'h410, 1'b0, 64);
        push(0, 32'h110, 1'b0, 64);
        grants = 0;
        req_valid = 4'b1111;
        for (int i = 0; i < 3000 && grants < 5; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        drain();
        check("t2_grants", 64'(grants), 64'd5);
        check("t2_jobs_done", 64'(jobs_done), 64'd5);

        // Watchdog: first pass never completes; last good value is the seed.
        stub_hang = 1'b1;
        set_seed(1, 32'hDEAD_BEEF);
        push(1, 32'hDEAD_BEEF, 1'b1, 65);
        req_valid[1] = 1'b1;
        wait_grant(1);
        req_valid[1] = 1'b0;
        drain();
        stub_hang = 1'b0;
        set_seed(1, 32'h5);
        push(1, 32'h15, 1'b0, 64);
        req_valid[1] = 1'b1;
        wait_grant(1);
        req_valid[1] = 1'b0;
        drain();

        // Done on the final watchdog cycle of every pass is accepted.
        stub_delay = 64;
        set_seed(3, 32'h1000);
        push(3, 32'h1010, 1'b0, 16 * 65);
        req_valid[3] = 1'b1;
        wait_grant(3);
        req_valid[3] = 1'b0;
        drain();
        stub_delay = 3;
        check("t4_jobs_done", 64'(jobs_done), 64'd8);

        // Backpressure: response held for 10 cycles, no grants meanwhile.
        rsp_ready = 1'b0;
        set_seed(0, 32'hA0);
        push(0, 32'hB0, 1'b0, 64);
        req_valid[0] = 1'b1;
        wait_grant(0);
        req_valid[0] = 1'b0;
        for (int i = 0; i < 2000 && !rsp_valid; i++) @(negedge clk);
        set_seed(2, 32'h7);
        req_valid[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_data", 64'(rsp_data), 64'hB0);
            check("hold_no_grant", 64'(req_ready), 64'd0);
            check("hold_jobs_done", 64'(jobs_done), 64'd8);
        end
        push(2, 32'h17, 1'b0, 64);
        rsp_ready = 1'b1;
        wait_grant(2);
        req_valid[2] = 1'b0;
        drain();
        check("t5_jobs_done", 64'(jobs_done), 64'd10);

        // Reset during WAIT of round 5 of a job from requester 2 (rr_ptr is then 3).
        set_seed(2, 32'h50);
        req_valid[2] = 1'b1;
        wait_grant(2);
        req_valid[2] = 1'b0;
        begin
            int n = 0;
            if (core_start) n++;
            for (int i = 0; i < 500 && n < 6; i++) begin
                @(negedge clk);
                if (core_start) n++;
            end
            check("t6_starts", 64'(n), 64'd6);
        end
        @(negedge clk);
        rst_n = 1'b0; exp_jobs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_busy", 64'(busy), 64'd0);
            check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("post_rst_core_start", 64'(core_start), 64'd0);
        end
        check("post_rst_jobs_done", 64'(jobs_done), 64'd0);
        set_seed(2, 32'h60);
        set_seed(3, 32'h80);
        push(2, 32'h70, 1'b0, 64);
        push(3, 32'h90, 1'b0, 64);
        req_valid = 4'b1100;
        wait_grant(2);
        req_valid[2] = 1'b0;
        wait_grant(3);
        req_valid[3] = 1'b0;
        drain();
        check("t6_jobs_done", 64'(jobs_done), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
